// File: rtl/game_pkg.sv
// Shared game-flow state encoding and default constants for the controller, renderer and display.
package game_pkg;

  typedef enum logic [2:0] {
    StInitial  = 3'd0,
    StStart    = 3'd1,
    StPlay     = 3'd2,
    StHit      = 3'd3,
    StGameover = 3'd4,
    StPause    = 3'd5
  } game_state_e;

  localparam int unsigned DefHeartW       = 3;
  localparam int unsigned DefMaxHearts    = 5;
  localparam int unsigned DefStartHearts  = 3;
  localparam int unsigned DefTimerW       = 28;
  localparam int unsigned DefInitCycles   = 20_000_000;
  localparam int unsigned DefInvulnCycles = 200_000_000;

  function automatic int unsigned sat_inc(input int unsigned value, input int unsigned limit);
    return (value >= limit) ? limit : value + 1;
  endfunction

endpackage

// File: rtl/game_ctrl_fsm_if.sv
// Key/collision inputs and display/world control outputs of the game-flow controller.
interface game_ctrl_fsm_if #(
  parameter int unsigned HEART_W = game_pkg::DefHeartW
);
  logic               enter;
  logic               pause;
  logic               collision;
  logic               life_up;
  logic [HEART_W-1:0] num_heart;
  logic [2:0]         gamestate;
  logic               game_en;
  logic               game_reset;
  logic               invuln;

  modport master (
    output enter, pause, collision, life_up,
    input  num_heart, gamestate, game_en, game_reset, invuln
  );

  modport slave (
    input  enter, pause, collision, life_up,
    output num_heart, gamestate, game_en, game_reset, invuln
  );
endinterface

// File: rtl/rise_edge.sv
// Registered rising-edge detector: one-cycle pulse the cycle after x goes high.
module rise_edge (
  input  logic clk,
  input  logic hard_reset,
  input  logic x,
  output logic rise
);
  logic x_q;

  // The pulse itself is registered so every key event sees one extra stage.
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      x_q  <= 1'b0;
      rise <= 1'b0;
    end else begin
      x_q  <= x;
      rise <= x & ~x_q;
    end
  end
endmodule

// File: rtl/game_ctrl_fsm.sv
// Game-flow controller: boot wait, start, play, invulnerability, game-over, hearts.
// Pause support (PAUSE state, saved return state) is built only with GAME_PAUSE_EN defined.
module game_ctrl_fsm
  import game_pkg::*;
#(
  parameter int unsigned HEART_W       = DefHeartW,
  parameter int unsigned MAX_HEARTS    = DefMaxHearts,
  parameter int unsigned START_HEARTS  = DefStartHearts,
  parameter int unsigned TIMER_W       = DefTimerW,
  parameter int unsigned INIT_CYCLES   = DefInitCycles,
  parameter int unsigned INVULN_CYCLES = DefInvulnCycles
) (
  input logic            clk,
  input logic            hard_reset,
  game_ctrl_fsm_if.slave bus
);

  if (!(START_HEARTS >= 1 && START_HEARTS <= MAX_HEARTS &&
        64'(MAX_HEARTS) < (64'd1 << HEART_W))) begin : gen_heart_chk
    $error("game_ctrl_fsm: heart parameters out of range");
  end
  if (!(INIT_CYCLES >= 1 && INVULN_CYCLES >= 1 &&
        64'(INIT_CYCLES) - 64'd1 < (64'd1 << TIMER_W) &&
        64'(INVULN_CYCLES) - 64'd1 < (64'd1 << TIMER_W))) begin : gen_timer_chk
    $error("game_ctrl_fsm: timer parameters out of range");
  end

  localparam logic [TIMER_W-1:0] InitLoad   = TIMER_W'(INIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] InvulnLoad = TIMER_W'(INVULN_CYCLES - 1);
  localparam logic [HEART_W-1:0] StartLoad  = HEART_W'(START_HEARTS);

  game_state_e        state_q, state_d;
  logic [HEART_W-1:0] hearts_q, hearts_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               game_reset_q, game_reset_d;
  logic               game_en_q, invuln_q;
  logic               enter_rise, collision_q, life_up_q;

  rise_edge u_enter_edge (
    .clk       (clk),
    .hard_reset(hard_reset),
    .x         (bus.enter),
    .rise      (enter_rise)
  );

`ifdef GAME_PAUSE_EN
  logic        pause_rise;
  game_state_e saved_q, saved_d;

  rise_edge u_pause_edge (
    .clk       (clk),
    .hard_reset(hard_reset),
    .x         (bus.pause),
    .rise      (pause_rise)
  );

  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) saved_q <= StPlay;
    else            saved_q <= saved_d;
  end
`else
  logic unused_pause;
  assign unused_pause = bus.pause;
`endif

  // Level inputs take the same one-stage delay as the key edges to keep them aligned.
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      collision_q <= 1'b0;
      life_up_q   <= 1'b0;
    end else begin
      collision_q <= bus.collision;
      life_up_q   <= bus.life_up;
    end
  end

  always_comb begin
    state_d      = state_q;
    hearts_d     = hearts_q;
    timer_d      = timer_q;
    game_reset_d = 1'b0;
`ifdef GAME_PAUSE_EN
    saved_d      = saved_q;
`endif
    case (state_q)
      StInitial: begin
        if (timer_q == '0) state_d = StStart;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      StStart: begin
        if (enter_rise) begin
          state_d      = StPlay;
          hearts_d     = StartLoad;
          game_reset_d = 1'b1;
        end
      end
      StPlay: begin
        if (collision_q) begin
          if (hearts_q <= HEART_W'(1)) begin
            hearts_d = '0;
            state_d  = StGameover;
          end else begin
            hearts_d = hearts_q - HEART_W'(1);
            timer_d  = InvulnLoad;
            state_d  = StHit;
          end
        end
`ifdef GAME_PAUSE_EN
        else if (pause_rise) begin
          saved_d = StPlay;
          state_d = StPause;
        end
`endif
        else if (life_up_q) begin
          hearts_d = HEART_W'(sat_inc(32'(hearts_q), MAX_HEARTS));
        end
      end
      StHit: begin
`ifdef GAME_PAUSE_EN
        // The pausing cycle counts as elapsed; if none remain, resume straight into PLAY.
        if (pause_rise) begin
          state_d = StPause;
          if (timer_q == '0) begin
            saved_d = StPlay;
          end else begin
            saved_d = StHit;
            timer_d = timer_q - TIMER_W'(1);
          end
        end else
`endif
        begin
          if (life_up_q) hearts_d = HEART_W'(sat_inc(32'(hearts_q), MAX_HEARTS));
          if (timer_q == '0) state_d = StPlay;
          else               timer_d = timer_q - TIMER_W'(1);
        end
      end
      StGameover: begin
        if (enter_rise) begin
          state_d      = StInitial;
          hearts_d     = StartLoad;
          timer_d      = InitLoad;
          game_reset_d = 1'b1;
        end
      end
`ifdef GAME_PAUSE_EN
      StPause: begin
        if (pause_rise) state_d = saved_q;
      end
`endif
      default: begin
        state_d = StInitial;
        timer_d = InitLoad;
      end
    endcase
  end

  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      state_q      <= StInitial;
      hearts_q     <= StartLoad;
      timer_q      <= InitLoad;
      game_en_q    <= 1'b0;
      game_reset_q <= 1'b0;
      invuln_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hearts_q     <= hearts_d;
      timer_q      <= timer_d;
      game_en_q    <= (state_d == StPlay) || (state_d == StHit);
      game_reset_q <= game_reset_d;
      invuln_q     <= (state_d == StHit);
    end
  end

  assign bus.gamestate  = state_q;
  assign bus.num_heart  = hearts_q;
  assign bus.game_en    = game_en_q;
  assign bus.game_reset = game_reset_q;
  assign bus.invuln     = invuln_q;

endmodule

// File: doc/game_ctrl_fsm.md
# game_ctrl_fsm

Parametrised game-flow controller, successor to the fixed three-heart game FSM. Sequences the game through boot wait, start, play, post-hit invulnerability, pause and game-over. Tracks a configurable heart count with saturating extra-life pickups. Drives the enable, reset and state signals consumed by the renderer, the obstacle generator and the score/heart display.

## Interface
- `HEART_W`, 3, width of the heart counter.
- `MAX_HEARTS`, 5, saturation limit for `life_up`.
- `START_HEARTS`, 3, hearts loaded at reset and on every new game.
- `TIMER_W`, 28, width of the shared down-counter.
- `INIT_CYCLES`, 20_000_000, length of INITIAL in cycles.
- `INVULN_CYCLES`, 200_000_000, length of HIT in cycles (pause time not counted).
- `clk`  in  1  system clock.
- `hard_reset`  in  1  reset, asynchronous, active-high.
- `enter`  in  1  start/restart key, level, synchronous and debounced.
- `pause`  in  1  pause toggle key, level, synchronous and debounced.
- `collision`  in  1  player/obstacle overlap, level.
- `life_up`  in  1  extra-life pickup, one-cycle pulse.
- `num_heart`  out  HEART_W  current hearts.
- `gamestate`  out  3  encoded state.
- `game_en`  out  1  world advances when high.
- `game_reset`  out  1  one-cycle pulse that clears score and world.
- `invuln`  out  1  high while in HIT; the renderer uses it for blinking.

## Operation
- State encoding: INITIAL=0, START=1, PLAY=2, HIT=3, GAMEOVER=4, PAUSE=5. Codes 6 and 7 are illegal and return to INITIAL on the next cycle.
- Edge detection: `enter` and `pause` are registered, and each acts only on its rising edge (`x & ~x_q`). A held key never re-triggers.
- INITIAL: the timer counts down from INIT_CYCLES-1. At 0 the FSM goes to START. All inputs are ignored.
- START: an `enter` edge moves to PLAY. In the same transition, `game_en` goes to 1, `game_reset` pulses and hearts load START_HEARTS.
- PLAY, events by priority (only the highest acts):
  - 1. `collision`: if hearts ≤ 1, hearts go to 0, `game_en` goes to 0 and the FSM moves to GAMEOVER. Otherwise hearts decrement, the timer loads INVULN_CYCLES-1 and the FSM moves to HIT.
  - 2. `pause` edge: move to PAUSE.
  - 3. `life_up`: hearts increment, saturating at MAX_HEARTS.
  - A `life_up` in the same cycle as `collision` or a `pause` edge is dropped.
- HIT:
  - `collision` is ignored.
  - `life_up` is accepted and saturates.
  - The timer decrements. At 0 the FSM returns to PLAY.
  - A `pause` edge moves to PAUSE and takes priority over the timer reaching 0.
- PAUSE:
  - Entry saves the return state (PLAY or HIT) and forces `game_en` to 0.
  - The timer is frozen.
  - `collision`, `life_up` and `enter` are ignored.
  - A `pause` edge restores the saved state with its remaining timer and sets `game_en` back to 1.
- GAMEOVER: an `enter` edge moves to INITIAL. In the same transition, hearts load START_HEARTS, the timer loads INIT_CYCLES-1 and `game_reset` pulses.
- `game_en` is 1 only in PLAY and HIT.
- Elaboration checks:
  - 1 ≤ START_HEARTS ≤ MAX_HEARTS < 2**HEART_W.
  - INIT_CYCLES ≥ 1 and INVULN_CYCLES ≥ 1, and both fit in TIMER_W.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Reset values:
  - `gamestate` = INITIAL, `num_heart` = START_HEARTS.
  - `game_en` = 0, `game_reset` = 0, `invuln` = 0.
  - Timer = INIT_CYCLES-1, edge registers = 0, saved state = PLAY.
- Latency: an input sampled at edge N changes the state and outputs after edge N+1 (one register stage past the edge detector).
- `game_reset` is high for exactly the first cycle of the new state (PLAY or INITIAL), aligned with the `gamestate` update.
- INITIAL lasts exactly INIT_CYCLES cycles. HIT lasts exactly INVULN_CYCLES unpaused cycles.
- `invuln` is aligned with `gamestate` == HIT.
- `hard_reset` asserted in any state, including PAUSE and HIT, returns everything to its reset values immediately. The saved pause state is discarded.

## Configuration
- `GAME_PAUSE_EN` defined: PAUSE and the saved-state register are built, with behaviour as above.
- `GAME_PAUSE_EN` undefined:
  - The `pause` port remains but is ignored, and code 5 is unreachable (treated as illegal).
  - The saved-state register and the pause edge detector are not built.
  - All other behaviour is identical.

## Structure
- Shared package `game_pkg`: the state typedef/constants (INITIAL…PAUSE, width 3), plus default heart and timer constants used by the display and renderer.
- Sub-module `rise_edge`: register plus `x & ~x_q`, with asynchronous reset. Instantiated for `enter` and for `pause`.
- The timer is a single TIMER_W down-counter shared by INITIAL and HIT.

## Test plan
Bench parameters: INIT_CYCLES=4, INVULN_CYCLES=3, START_HEARTS=3, MAX_HEARTS=5.
- Release reset -> `gamestate`=0 for 4 cycles, then 1. `num_heart`=3, `game_en`=0.
- `enter` held high 5 cycles in START -> one transition to PLAY, `game_reset` high 1 cycle, `game_en`=1, no re-trigger.
- `collision` in PLAY -> HIT with `num_heart`=2 and `invuln`=1 for 3 cycles. A `collision` held throughout is ignored, then the FSM returns to PLAY.
- 3× `life_up` at hearts=3 -> 4, 5, 5. `collision` and `life_up` in the same cycle at hearts=5 -> 4.
- Collisions spaced past invulnerability from hearts=3 -> 2, 1, then GAMEOVER with hearts=0 and `game_en`=0. `enter` -> INITIAL, hearts=3, `game_reset` pulse.
- `pause` edge in HIT with 2 cycles left -> PAUSE, `game_en`=0. Held 10 cycles with `collision`/`life_up` toggling, no change. `pause` edge -> HIT, 2 more cycles, then PLAY. `hard_reset` while in PAUSE -> INITIAL with reset values.
